apmu_ibex_register_file_fpga_mp: RTL
====================================

// Module: apmu_ibex_register_file_fpga_mp
// PURPOSE
// - Multi-read-port FPGA register file for the Ibex core. Replaces the 2-read/1-write file.
// - Holds 31 (RV32E=0) or 15 (RV32E=1) general registers of DataWidth bits; x0 always reads 0.
// - Storage is written with no reset, so FPGA tools infer distributed RAM.
// - A post-reset scrub FSM walks every address and writes zero, giving known contents after reset.
// - Third/fourth read ports serve APMU-side register observation alongside the two ID-stage ports.
// PARAMETERS
// - RV32E        default 0   1: 16 entries (4-bit address used), 0: 32 entries
// - DataWidth    default 32  register width in bits
// - NumReadPorts default 2   asynchronous read ports; legal range 2..4
// PORTS
// - clk_i      in   1                 clock; all state updates on rising edge
// - rst_ni     in   1                 reset, asynchronous, active-low
// - raddr_i    in   5*NumReadPorts    read address of port p at [5p+4:5p]
// - rdata_o    out  DataWidth*NumReadPorts  read data of port p at [DW*p+DW-1:DW*p]
// - waddr_a_i  in   5                 write address
// - wdata_a_i  in   DataWidth         write data
// - we_a_i     in   1                 write enable
// - ready_o    out  1                 1 = scrub complete, file accepts writes
// - wr_drop_o  out  1                 registered pulse: a write was discarded during scrub
// BEHAVIOUR
// - Reset: asynchronous, active-low on rst_ni.
//   - FSM enters SCRUB; scrub pointer = 1; ready_o = 0; wr_drop_o = 0.
//   - mem itself is not reset.
// - SCRUB state:
//   - Each cycle writes 0 to mem[ptr], then increments ptr.
//   - When ptr == NUM_WORDS-1 is written, the next state is READY.
//   - Scrub takes NUM_WORDS-1 cycles after reset release (31, or 15 when RV32E).
//   - ready_o rises on the first READY cycle.
// - READY is terminal until the next reset.
//   - Reset asserted mid-scrub restarts at ptr = 1.
// - Reads:
//   - Combinational, zero latency.
//   - Address 0 returns 0.
//   - In SCRUB every port returns 0, whatever the address or mem contents.
//   - RV32E: only address bits [3:0] index mem; bit 4 is ignored.
// - Writes: qualified write = we_a_i & ready_o & (waddr_a_i != 0).
//   - A qualified write updates mem on the rising edge; visible on read ports the next cycle.
//   - Writes to x0 are silently ignored and do not pulse wr_drop_o.
// - Dropped writes: we_a_i=1 with waddr_a_i != 0 while ready_o=0.
//   - The write is discarded.
//   - wr_drop_o = 1 for exactly the following cycle, and 0 otherwise.
// - Simultaneous events:
//   - Multiple read ports may read the same address; all return identical data.
//   - Read of the address being written returns the pre-write value unless bypass is built in.
// - Width rules: data is never truncated or extended; DataWidth applies to all ports and mem.
// CONFIGURATION
// - Macro APMU_RF_WRITE_BYPASS_EN.
// - Defined:
//   - Any read port whose address equals waddr_a_i during a qualified write returns wdata_a_i
//     in the same cycle.
//   - Combinational forwarding; x0 and SCRUB rules still take priority.
// - Undefined:
//   - No forwarding; read returns the stored value until the edge after the write.
//   - No extra logic is generated.
// TESTING
// - Scrub timing: release rst_ni, RV32E=0.
//   - ready_o low for exactly 31 cycles, then high.
//   - All 31 registers then read 0x0000_0000.
// - Basic write/read: write 0xDEAD_BEEF to x5; next cycle raddr port0=5, port1=5.
//   - Both ports return 0xDEAD_BEEF.
//   - Read of x0 returns 0 after a write of 0x1234 to x0.
// - Dropped write: we_a_i=1, waddr=7, wdata=0xA5A5 at cycle 3 of scrub.
//   - wr_drop_o=1 the next cycle only; x7 reads 0 after ready_o.
// - Reset mid-scrub: assert rst_ni=0 at scrub cycle 10.
//   - ready_o=0 immediately; after release, ready_o rises 31 cycles later.
// - Bypass: write 0x0000_0042 to x9 with port2 reading x9 (NumReadPorts=3).
//   - With APMU_RF_WRITE_BYPASS_EN: port2=0x42 in the same cycle.
//   - Without it: old value in that cycle, 0x42 in the next.
// - RV32E=1:
//   - Scrub completes after 15 cycles.
//   - Write 0x77 to x3, read address 19 (bit 4 set) -> 0x77.

Source files
------------

// File: rtl/apmu_ibex_register_file_fpga_mp.sv
// -----------------------------------------------------------------------------
// apmu_ibex_register_file_fpga_mp
//
// Multi-read-port FPGA register file for the Ibex core. Holds 31 (RV32E=0) or
// 15 (RV32E=1) general registers of DataWidth bits; x0 always reads zero.
// Storage carries no reset so it maps onto distributed RAM. After reset a
// scrub FSM walks addresses 1..NUM_WORDS-1 writing zero, then the file
// enters READY and starts accepting writes. Writes attempted while scrubbing
// are discarded and reported with a one-cycle wr_drop_o pulse.
//
// Optional feature (macro APMU_RF_WRITE_BYPASS_EN):
//   defined   - a read port whose address matches a qualified write returns
//               wdata_a_i in the same cycle (x0 and scrub rules still win).
//   undefined - no forwarding; the written value appears after the edge.
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_ni     in   asynchronous active-low reset
//   raddr_i    in   5*NumReadPorts; port p address at [5p+4:5p]
//   rdata_o    out  DataWidth*NumReadPorts; port p data at [DW*p+DW-1:DW*p]
//   waddr_a_i  in   write address
//   wdata_a_i  in   write data
//   we_a_i     in   write enable
//   ready_o    out  1 = scrub complete, writes accepted
//   wr_drop_o  out  registered pulse: a write was discarded during scrub
// -----------------------------------------------------------------------------
module apmu_ibex_register_file_fpga_mp #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumReadPorts = 2     // legal range 2..4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [5*NumReadPorts-1:0]         raddr_i,
  output logic [DataWidth*NumReadPorts-1:0] rdata_o,
  input  logic [4:0]                        waddr_a_i,
  input  logic [DataWidth-1:0]              wdata_a_i,
  input  logic                              we_a_i,
  output logic                              ready_o,
  output logic                              wr_drop_o
);

  localparam int unsigned AddrW    = RV32E ? 4 : 5;
  localparam int unsigned NumWords = 2 ** AddrW;

  typedef enum logic {
    ST_SCRUB,
    ST_READY
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [AddrW-1:0]       r_ptr;
  logic                   r_wr_drop;
  logic [DataWidth-1:0]   r_mem [NumWords];

  logic [AddrW-1:0]       w_widx;
  logic                   w_waddr_nz;
  logic                   w_we_q;
  logic                   w_we_drop;

  // In RV32E only the low four address bits select a register.
  assign w_widx     = waddr_a_i[AddrW-1:0];
  assign w_waddr_nz = |w_widx;
  assign ready_o    = (r_state == ST_READY);
  assign w_we_q     = we_a_i &  ready_o & w_waddr_nz;
  assign w_we_drop  = we_a_i & ~ready_o & w_waddr_nz;
  assign wr_drop_o  = r_wr_drop;

  // Scrub ends once the last address (all ones) has been written; READY is
  // terminal until the next reset.
  always_comb begin
    // NOTE: default assigned first so no path through the block infers a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_SCRUB: if (r_ptr == '1) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments for all clocked state so every reader
    // sees the pre-edge value regardless of block ordering.
    if (!rst_ni) begin
      r_state   <= ST_SCRUB;
      r_ptr     <= AddrW'(1);
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      if (r_state == ST_SCRUB) r_ptr <= r_ptr + 1'b1;
      r_wr_drop <= w_we_drop;
    end
  end

  // NOTE: the storage array has no reset on purpose; a reset would stop the
  // tools from mapping it to distributed RAM. The scrub FSM clears it instead.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_SCRUB) begin
      r_mem[r_ptr] <= '0;
    end else if (w_we_q) begin
      r_mem[w_widx] <= wdata_a_i;
    end
  end

  // Asynchronous read ports. Zero while scrubbing or for x0; otherwise the
  // stored word, optionally overridden by a same-cycle qualified write.
  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [AddrW-1:0]     w_ridx;
    logic [DataWidth-1:0] w_rdata;

    assign w_ridx = raddr_i[5*p +: AddrW];

    always_comb begin
      w_rdata = '0;
      if (ready_o && (w_ridx != '0)) begin
        w_rdata = r_mem[w_ridx];
`ifdef APMU_RF_WRITE_BYPASS_EN
        if (w_we_q && (w_ridx == w_widx)) w_rdata = wdata_a_i;
`endif
      end
    end

    assign rdata_o[DataWidth*p +: DataWidth] = w_rdata;
  end

endmodule
